reaction_capture: RTL and testbench
===================================

REACTION_CAPTURE -- requirements
Module: reaction_capture

Interface
REQ-001 Parameter MIN_WAIT_MS, default 1000: fixed part of the random pre-stimulus wait, in ms ticks.
REQ-002 Parameter WAIT_STEP_MS, default 16: ms added per unit of delay_seed.
REQ-003 Parameter MAX_MS, default 9999: reaction count ceiling and timeout value.
REQ-004 clk  input  1  system clock; all logic on posedge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 ms_tick  input  1  one-clk-wide enable pulse at 1 kHz from the clock divider.
REQ-007 start  input  1  begin a run; sampled high for one clk.
REQ-008 button  input  1  raw asynchronous user button, active-high.
REQ-009 delay_seed  input  7  random value from the LFSR, sampled on accepted start.
REQ-010 led  output  1  stimulus indicator.
REQ-011 busy  output  1  high in WAIT or STIM.
REQ-012 reaction_ms  output  14  last captured reaction time in ms.
REQ-013 result_valid  output  1  one-clk pulse when reaction_ms updates.
REQ-014 false_start  output  1  sticky flag: button pressed before stimulus.
REQ-015 timeout  output  1  sticky flag: no press before MAX_MS.
REQ-016 best_ms  output  14  best (minimum) valid reaction time; see Configuration.

Function
REQ-017 button SHALL pass through a 2-flop synchronizer; a press SHALL be a 0->1 edge of the synchronized signal (press event 3 clk after the raw rise at most).
REQ-018 FSM states SHALL be IDLE, WAIT, STIM, DONE, FAULT.
REQ-019 IDLE/DONE/FAULT + start: load wait_cnt (16 bit) = MIN_WAIT_MS + delay_seed*WAIT_STEP_MS; clear false_start, timeout; go to WAIT.
REQ-020 start while busy SHALL be ignored.
REQ-021 WAIT: decrement wait_cnt on each ms_tick; on the ms_tick that finds wait_cnt==1, go to STIM with led=1 and rt_cnt=0 on the next clk.
REQ-022 WAIT + press event: go to FAULT, false_start=1, led stays 0, reaction_ms unchanged, no result_valid.
REQ-023 WAIT, press event and final ms_tick in same clk: press wins (FAULT).
REQ-024 STIM: rt_cnt increments on each ms_tick.
REQ-025 STIM + press event: reaction_ms <= rt_cnt value before any same-cycle increment; result_valid=1 next clk for one clk; led=0; go to DONE.
REQ-026 STIM, rt_cnt reaches MAX_MS without press: reaction_ms <= MAX_MS, timeout=1, result_valid pulses, led=0, go to DONE.
REQ-027 Press events in IDLE, DONE, FAULT SHALL be ignored.
REQ-028 busy SHALL be combinational decode of state (WAIT or STIM).

Reset
REQ-029 rst_n low SHALL force immediately: state IDLE, led 0, result_valid 0, false_start 0, timeout 0, reaction_ms 0, best_ms MAX_MS, counters 0, synchronizer flops 0.
REQ-030 Reset mid-run SHALL abort without result_valid; first accepted start after release begins a fresh run.

Configuration
REQ-031 Macro REACTION_CAPTURE_BEST_EN defined: best_ms <= reaction_ms whenever result_valid fires without timeout and new value < best_ms; cleared only by reset.
REQ-032 Macro undefined: best-time register absent, best_ms tied to MAX_MS.

Verification
REQ-033 seed=10, defaults: start, no press -> led rises on the clk after the 1160th ms_tick; timeout=1, reaction_ms=9999 after 9999 further ticks.
REQ-034 seed=0: start, press after 250 ticks in STIM -> result_valid one clk, reaction_ms=250, led=0, state DONE.
REQ-035 seed=5: press at tick 500 of WAIT -> false_start=1, led never rises, no result_valid; next start clears false_start.
REQ-036 Press edge coincident with final WAIT ms_tick -> FAULT; press coincident with STIM tick 42 -> reaction_ms=42.
REQ-037 REACTION_CAPTURE_BEST_EN: runs of 300, 200, 400 ms -> best_ms=200; without macro best_ms=9999 throughout.
REQ-038 rst_n low at STIM tick 100 -> all outputs at reset values immediately, no result_valid; subsequent start runs normally.

Source files
------------

// File: rtl/reaction_capture_if.sv
// Bundle of control inputs and result outputs for the reaction-time capture block.
interface reaction_capture_if;
    logic        ms_tick;
    logic        start;
    logic        button;
    logic [6:0]  delay_seed;
    logic        led;
    logic        busy;
    logic [13:0] reaction_ms;
    logic        result_valid;
    logic        false_start;
    logic        timeout;
    logic [13:0] best_ms;

    modport master (
        output ms_tick, start, button, delay_seed,
        input  led, busy, reaction_ms, result_valid, false_start, timeout, best_ms
    );

    modport slave (
        input  ms_tick, start, button, delay_seed,
        output led, busy, reaction_ms, result_valid, false_start, timeout, best_ms
    );
endinterface

// File: rtl/reaction_capture.sv
// Reaction timer: random wait, lights led, measures ms to button press; best time under REACTION_CAPTURE_BEST_EN.
// Latency: press acted on <=3 clk after raw button rise; result_valid one clk after the deciding edge.
// Backpressure: none; start is ignored while busy, results are pulses with no handshake.
module reaction_capture #(
    parameter int MIN_WAIT_MS  = 1000,
    parameter int WAIT_STEP_MS = 16,
    parameter int MAX_MS       = 9999
) (
    input  logic              clk,
    input  logic              rst_n,
    reaction_capture_if.slave bus
);

    typedef enum logic [2:0] {IDLE, WAIT, STIM, DONE, FAULT} state_t;

    state_t      state;
    logic [15:0] wait_cnt;
    logic [13:0] rt_cnt;
    logic        btn_s1, btn_s2, btn_prev;
    logic        led;
    logic        result_valid;
    logic        false_start;
    logic        timeout;
    logic [13:0] reaction_ms;
    logic        press;
    logic [15:0] wait_load;

    assign press     = btn_s2 & ~btn_prev;
    assign wait_load = 16'(MIN_WAIT_MS) + 16'(bus.delay_seed) * 16'(WAIT_STEP_MS);

`ifdef REACTION_CAPTURE_BEST_EN
    logic [13:0] best_ms;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            rt_cnt       <= '0;
            btn_s1       <= 1'b0;
            btn_s2       <= 1'b0;
            btn_prev     <= 1'b0;
            led          <= 1'b0;
            result_valid <= 1'b0;
            false_start  <= 1'b0;
            timeout      <= 1'b0;
            reaction_ms  <= '0;
`ifdef REACTION_CAPTURE_BEST_EN
            best_ms      <= 14'(MAX_MS);
`endif
        end else begin
            btn_s1       <= bus.button;
            btn_s2       <= btn_s1;
            btn_prev     <= btn_s2;
            result_valid <= 1'b0;
            case (state)
                IDLE, DONE, FAULT: begin
                    if (bus.start) begin
                        wait_cnt    <= wait_load;
                        false_start <= 1'b0;
                        timeout     <= 1'b0;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    // A press on the final tick still counts as anticipating the stimulus.
                    if (press) begin
                        false_start <= 1'b1;
                        state       <= FAULT;
                    end else if (bus.ms_tick) begin
                        wait_cnt <= wait_cnt - 16'd1;
                        if (wait_cnt <= 16'd1) begin
                            led    <= 1'b1;
                            rt_cnt <= '0;
                            state  <= STIM;
                        end
                    end
                end
                STIM: begin
                    if (press) begin
                        reaction_ms  <= rt_cnt;
                        result_valid <= 1'b1;
                        led          <= 1'b0;
                        state        <= DONE;
`ifdef REACTION_CAPTURE_BEST_EN
                        if (rt_cnt < best_ms)
                            best_ms <= rt_cnt;
`endif
                    end else if (bus.ms_tick) begin
                        if (rt_cnt == 14'(MAX_MS - 1)) begin
                            rt_cnt       <= 14'(MAX_MS);
                            reaction_ms  <= 14'(MAX_MS);
                            timeout      <= 1'b1;
                            result_valid <= 1'b1;
                            led          <= 1'b0;
                            state        <= DONE;
                        end else begin
                            rt_cnt <= rt_cnt + 14'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.led          = led;
    assign bus.busy         = (state == WAIT) || (state == STIM);
    assign bus.reaction_ms  = reaction_ms;
    assign bus.result_valid = result_valid;
    assign bus.false_start  = false_start;
    assign bus.timeout      = timeout;
`ifdef REACTION_CAPTURE_BEST_EN
    assign bus.best_ms      = best_ms;
`else
    assign bus.best_ms      = 14'(MAX_MS);
`endif

endmodule

// File: tb/tb_reaction_capture.sv
// Directed + randomized bench for reaction_capture against a tick-count reference model.
module tb_reaction_capture;

    localparam int MIN_WAIT = 1000;
    localparam int STEP     = 16;
    localparam int MAXV     = 9999;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    reaction_capture_if rc ();

    reaction_capture #(.MIN_WAIT_MS(MIN_WAIT), .WAIT_STEP_MS(STEP), .MAX_MS(MAXV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (rc.slave)
    );

    int checks = 0;
    int errors = 0;
    int rv_count = 0;
    int rv0;
    int model_rm;
    int model_best;

    always @(negedge clk) if (rc.result_valid === 1'b1) rv_count++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_best();
`ifdef REACTION_CAPTURE_BEST_EN
        return model_best;
`else
        return MAXV;
`endif
    endfunction

    task automatic tick_n(input int n);
        repeat (n) begin
            rc.ms_tick = 1'b1;
            @(negedge clk);
            rc.ms_tick = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic do_start(input int seed);
        rc.delay_seed = 7'(seed);
        rc.start = 1'b1;
        @(negedge clk);
        rc.start = 1'b0;
        @(negedge clk);
    endtask

    // Raw rise two clocks ahead so the synchronized edge lands with the optional tick.
    task automatic press(input bit with_tick);
        rc.button = 1'b1;
        @(negedge clk);
        @(negedge clk);
        if (with_tick) rc.ms_tick = 1'b1;
        @(negedge clk);
        rc.ms_tick = 1'b0;
    endtask

    task automatic release_btn();
        rc.button = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic run_to_stim(input int seed);
        int w;
        w = MIN_WAIT + seed * STEP;
        do_start(seed);
        check("busy_wait", rc.busy, 1);
        tick_n(w - 1);
        check("led_before_stim", rc.led, 0);
        tick_n(1);
        check("led_rise", rc.led, 1);
    endtask

    task automatic valid_run(input int seed, input int react, input bit with_tick, input string tag);
        run_to_stim(seed);
        tick_n(react);
        rv0 = rv_count;
        press(with_tick);
        model_rm = react;
        if (react < model_best) model_best = react;
        check({tag, "_rv"}, rc.result_valid, 1);
        check({tag, "_rm"}, rc.reaction_ms, model_rm);
        check({tag, "_led"}, rc.led, 0);
        check({tag, "_busy"}, rc.busy, 0);
        check({tag, "_to"}, rc.timeout, 0);
        release_btn();
        check({tag, "_rv_pulses"}, rv_count - rv0, 1);
        check({tag, "_best"}, rc.best_ms, exp_best());
    endtask

    initial begin
        int seed, react;
        rst_n = 1'b0;
        rc.ms_tick = 1'b0;
        rc.start = 1'b0;
        rc.button = 1'b0;
        rc.delay_seed = '0;
        model_rm = 0;
        model_best = MAXV;
        repeat (3) @(negedge clk);
        check("rst_led", rc.led, 0);
        check("rst_busy", rc.busy, 0);
        check("rst_rv", rc.result_valid, 0);
        check("rst_fs", rc.false_start, 0);
        check("rst_to", rc.timeout, 0);
        check("rst_rm", rc.reaction_ms, 0);
        check("rst_best", rc.best_ms, MAXV);
        rst_n = 1'b1;
        @(negedge clk);

        // Best-time tracking over a 300/200/400 sequence with random wait seeds.
        valid_run($urandom_range(0, 15), 300, 1'b0, "run300");
        valid_run($urandom_range(0, 15), 200, 1'b0, "run200");
        valid_run($urandom_range(0, 15), 400, 1'b0, "run400");
`ifdef REACTION_CAPTURE_BEST_EN
        check("best_after_seq", rc.best_ms, 200);
`else
        check("best_after_seq", rc.best_ms, MAXV);
`endif

        // Press in DONE must not produce a result.
        rv0 = rv_count;
        press(1'b0);
        release_btn();
        check("done_press_rv", rv_count - rv0, 0);
        check("done_press_rm", rc.reaction_ms, model_rm);

        // seed 10 timeout, with an ignored start mid-wait.
        do_start(10);
        tick_n(500);
        do_start(0);
        tick_n(659);
        check("to_led_pre", rc.led, 0);
        tick_n(1);
        check("to_led_rise", rc.led, 1);
        check("to_busy", rc.busy, 1);
        tick_n(MAXV - 1);
        check("to_led_hold", rc.led, 1);
        check("to_flag_early", rc.timeout, 0);
        rv0 = rv_count;
        tick_n(1);
        model_rm = MAXV;
        check("to_flag", rc.timeout, 1);
        check("to_rm", rc.reaction_ms, MAXV);
        check("to_led_off", rc.led, 0);
        check("to_busy_off", rc.busy, 0);
        repeat (2) @(negedge clk);
        check("to_rv_pulses", rv_count - rv0, 1);
        check("to_best", rc.best_ms, exp_best());

        valid_run(0, 250, 1'b0, "run250");

        // False start at WAIT tick 500, seed 5.
        do_start(5);
        check("start_clears_to", rc.timeout, 0);
        tick_n(499);
        rv0 = rv_count;
        press(1'b1);
        check("fs_flag", rc.false_start, 1);
        check("fs_led", rc.led, 0);
        check("fs_busy", rc.busy, 0);
        release_btn();
        tick_n(700);
        check("fs_led_never", rc.led, 0);
        press(1'b0);
        release_btn();
        check("fs_rv_none", rv_count - rv0, 0);
        check("fs_rm_kept", rc.reaction_ms, model_rm);

        // Restart clears the flag; press on the final wait tick is a false start.
        do_start(5);
        check("fs_cleared", rc.false_start, 0);
        tick_n(MIN_WAIT + 5 * STEP - 1);
        rv0 = rv_count;
        press(1'b1);
        check("final_tick_fs", rc.false_start, 1);
        check("final_tick_led", rc.led, 0);
        release_btn();
        check("final_tick_rv", rv_count - rv0, 0);

        valid_run(0, 42, 1'b1, "tick42");

        for (int i = 0; i < 2; i++) begin
            seed = $urandom_range(0, 20);
            react = $urandom_range(1, 800);
            valid_run(seed, react, 1'($urandom_range(0, 1)), "rand");
        end

        // Asynchronous reset at STIM tick 100.
        run_to_stim($urandom_range(0, 15));
        tick_n(100);
        rv0 = rv_count;
        rst_n = 1'b0;
        #1;
        model_rm = 0;
        model_best = MAXV;
        check("mid_rst_led", rc.led, 0);
        check("mid_rst_busy", rc.busy, 0);
        check("mid_rst_rm", rc.reaction_ms, 0);
        check("mid_rst_best", rc.best_ms, MAXV);
        check("mid_rst_fs", rc.false_start, 0);
        check("mid_rst_to", rc.timeout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_rst_rv", rv_count - rv0, 0);
        valid_run($urandom_range(0, 15), $urandom_range(1, 500), 1'b0, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
